pll_lock_sequencer: RTL and testbench
=====================================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 The block SHALL have parameter LOCK_STABLE_CYCLES, default 1000, meaning cycles pll_locked must stay high continuously before reset sequencing proceeds.
REQ-002 The block SHALL have parameter RST_HOLD_CYCLES, default 16, meaning cycles sys_rst_n is held low after the lock is qualified.
REQ-003 The block SHALL have parameter BLINK_DIV, default 50000000, meaning cycles between heartbeat toggles (0.5 s at 100 MHz).
REQ-004 Port: clk  in  1  system clock, the 100 MHz PLL outclk_0.
REQ-005 Port: rst_n  in  1  board reset; asynchronous, active-low.
REQ-006 Port: pll_locked  in  1  PLL locked flag, asynchronous to clk.
REQ-007 Port: soft_rst_req  in  1  single-cycle request to re-run the reset hold phase.
REQ-008 Port: sys_rst_n  out  1  registered active-low reset for downstream logic.
REQ-009 Port: ready  out  1  high only in state RUN.
REQ-010 Port: relock_cnt  out  8  count of lock losses seen in RUN, saturating.
REQ-011 Port: heartbeat  out  1  LED toggle proving the clock domain is running.

Function
REQ-012 pll_locked SHALL pass through a 2-flop synchronizer; all decisions use the synchronized lock_s.
REQ-013 The FSM SHALL have states WAIT_LOCK, STABLE, HOLD and RUN, with one shared cycle counter.
REQ-014 WAIT_LOCK: sys_rst_n=0, counter=0; lock_s=1 -> STABLE.
REQ-015 STABLE: counter increments each cycle; lock_s=0 -> WAIT_LOCK; counter=LOCK_STABLE_CYCLES-1 -> HOLD with counter cleared.
REQ-016 HOLD: sys_rst_n=0, counter increments; lock_s=0 -> WAIT_LOCK; counter=RST_HOLD_CYCLES-1 -> RUN.
REQ-017 RUN: sys_rst_n=1, ready=1; lock_s=0 -> WAIT_LOCK and relock_cnt+1, saturating at 255; soft_rst_req=1 -> HOLD with counter cleared.
REQ-018 If lock_s falls in the same cycle as soft_rst_req in RUN, lock loss SHALL win (-> WAIT_LOCK, relock_cnt increments).
REQ-019 soft_rst_req outside RUN SHALL be ignored.
REQ-020 sys_rst_n and ready SHALL be registered outputs decoded from the next state, so both change on the same edge as the state transition.
REQ-021 With pll_locked held high from the first edge that samples it high, sys_rst_n SHALL rise exactly LOCK_STABLE_CYCLES+RST_HOLD_CYCLES+3 rising edges after that edge.
REQ-022 sys_rst_n SHALL fall on the edge at which the FSM leaves RUN, which is 3 edges after pll_locked is first sampled low.
REQ-023 The heartbeat counter SHALL count only in RUN and toggle heartbeat when it reaches BLINK_DIV-1, then wrap to 0.
REQ-024 Outside RUN, heartbeat and the heartbeat counter SHALL be held at 0.
REQ-025 The counter width SHALL be sized by $clog2 of the largest of LOCK_STABLE_CYCLES and RST_HOLD_CYCLES, and SHALL never wrap in STABLE or HOLD.

Reset
REQ-026 rst_n low SHALL asynchronously force: state=WAIT_LOCK, synchronizer flops=0, counters=0, sys_rst_n=0, ready=0, relock_cnt=0, heartbeat=0.
REQ-027 rst_n asserted mid-sequence in any state SHALL abort the sequence; after release the block restarts from WAIT_LOCK.

Structure
REQ-028 Package pll_seq_pkg SHALL hold the state enum type and the default values of all three parameters.
REQ-029 The synchronizer SHALL be a separate sub-module, bit_sync (2-flop, async active-low reset, parameterized reset value); nothing else is split out.

Verification (LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4, BLINK_DIV=4)
REQ-030 Scenario 1: release rst_n, raise pll_locked and hold it -> sys_rst_n and ready rise exactly 15 edges later; relock_cnt=0.
REQ-031 Scenario 2: raise pll_locked for 5 cycles, drop it, then raise it again -> FSM returns to WAIT_LOCK; sys_rst_n rises 15 edges after the second rise.
REQ-032 Scenario 3: in RUN, drop pll_locked -> sys_rst_n falls 3 edges later and relock_cnt=1; repeat the loss 300 times -> relock_cnt=255.
REQ-033 Scenario 4: in RUN, pulse soft_rst_req -> sys_rst_n is low for exactly 4 cycles, then returns high; relock_cnt is unchanged.
REQ-034 Scenario 5: in RUN, pulse soft_rst_req in the same cycle pll_locked is sampled low by the synchronizer -> WAIT_LOCK and relock_cnt increments.
REQ-035 Scenario 6: in RUN, heartbeat toggles every 4 cycles; assert rst_n during HOLD -> all outputs go to 0 immediately and the sequence restarts cleanly.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and parameter defaults for the PLL lock / reset sequencer.
package pll_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK,
      STABLE,
      HOLD,
      RUN
   } state_t;

   localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1000;
   localparam int unsigned DEF_RST_HOLD_CYCLES    = 16;
   localparam int unsigned DEF_BLINK_DIV          = 50000000;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous level signal.
module bit_sync #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Qualifies PLL lock, sequences the downstream reset, counts relocks and
// drives a heartbeat LED while running.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
   parameter int unsigned RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES,
   parameter int unsigned BLINK_DIV          = DEF_BLINK_DIV
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       soft_rst_req,
   output logic       sys_rst_n,
   output logic       ready,
   output logic [7:0] relock_cnt,
   output logic       heartbeat
);

   localparam int unsigned CNT_MAX = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                                     LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned HB_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [HB_W-1:0]  HB_LAST     = HB_W'(BLINK_DIV - 1);

   logic             lock_s;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [HB_W-1:0]  hb_cnt;

   bit_sync #(
      .RESET_VAL(1'b0)
   ) u_lock_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (pll_locked),
      .q    (lock_s)
   );

   // Outputs are assigned alongside each transition so they track the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= WAIT_LOCK;
         cnt        <= '0;
         hb_cnt     <= '0;
         sys_rst_n  <= 1'b0;
         ready      <= 1'b0;
         relock_cnt <= '0;
         heartbeat  <= 1'b0;
      end else begin
         hb_cnt    <= '0;
         heartbeat <= 1'b0;
         case (state)
            WAIT_LOCK: begin
               cnt <= '0;
               if (lock_s) state <= STABLE;
            end
            STABLE: begin
               if (!lock_s) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == STABLE_LAST) begin
                  state <= HOLD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (!lock_s) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == HOLD_LAST) begin
                  state     <= RUN;
                  cnt       <= '0;
                  sys_rst_n <= 1'b1;
                  ready     <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               // Lock loss takes priority over a simultaneous soft reset request.
               if (!lock_s) begin
                  state     <= WAIT_LOCK;
                  cnt       <= '0;
                  sys_rst_n <= 1'b0;
                  ready     <= 1'b0;
                  if (relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
               end else if (soft_rst_req) begin
                  state     <= HOLD;
                  cnt       <= '0;
                  sys_rst_n <= 1'b0;
                  ready     <= 1'b0;
               end else if (hb_cnt == HB_LAST) begin
                  hb_cnt    <= '0;
                  heartbeat <= ~heartbeat;
               end else begin
                  hb_cnt    <= hb_cnt + 1'b1;
                  heartbeat <= heartbeat;
               end
            end
            default: begin
               state     <= WAIT_LOCK;
               cnt       <= '0;
               sys_rst_n <= 1'b0;
               ready     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: cycle-level reference model plus directed scenarios.
module tb_pll_lock_sequencer;

   localparam int L  = 8;
   localparam int R  = 4;
   localparam int BD = 4;

   logic       clk          = 1'b0;
   logic       rst_n        = 1'b0;
   logic       pll_locked   = 1'b0;
   logic       soft_rst_req = 1'b0;
   logic       sys_rst_n;
   logic       ready;
   logic [7:0] relock_cnt;
   logic       heartbeat;

   int  total  = 0;
   int  passed = 0;
   bit  cmp_en = 1'b1;

   // Model state: lock pipeline, consecutive qualified-lock edges, and the
   // run length at which ready is due.
   int  s1 = 0, s2 = 0;
   int  run_len  = 0;
   int  ready_at = L + R + 1;
   int  m_relock = 0;

   int  n, lows, last_t, first_t, prev_hb;

   pll_lock_sequencer #(
      .LOCK_STABLE_CYCLES(L),
      .RST_HOLD_CYCLES   (R),
      .BLINK_DIV         (BD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pll_locked  (pll_locked),
      .soft_rst_req(soft_rst_req),
      .sys_rst_n   (sys_rst_n),
      .ready       (ready),
      .relock_cnt  (relock_cnt),
      .heartbeat   (heartbeat)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int m_ready();
      return (run_len >= ready_at) ? 1 : 0;
   endfunction

   function automatic int m_hb();
      return m_ready() ? (((run_len - ready_at) / BD) % 2) : 0;
   endfunction

   initial begin
      int lf, was_ready;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            s1 = 0; s2 = 0; run_len = 0; ready_at = L + R + 1; m_relock = 0;
         end else begin
            lf = s2; s2 = s1; s1 = int'(pll_locked);
            was_ready = m_ready();
            if (lf == 0) begin
               if (was_ready != 0 && m_relock < 255) m_relock++;
               run_len  = 0;
               ready_at = L + R + 1;
            end else begin
               run_len++;
               if (was_ready != 0 && soft_rst_req) ready_at = run_len + R;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_sys_rst_n", int'(sys_rst_n), m_ready());
         check("cyc_ready", int'(ready), m_ready());
         check("cyc_relock_cnt", int'(relock_cnt), m_relock);
         check("cyc_heartbeat", int'(heartbeat), m_hb());
      end
   end

   task automatic align();
      @(negedge clk); #1;
   endtask

   task automatic tick(input int k);
      repeat (k) begin @(negedge clk); #1; end
   endtask

   // Rising edges until sys_rst_n reads as 'val'; -1 on timeout.
   task automatic wait_rst(input logic val, output int edges);
      edges = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (sys_rst_n == val) begin
            edges = i;
            break;
         end
      end
   endtask

   initial begin
      tick(3);
      rst_n = 1'b1;
      tick(2);
      check("reset_sys_rst_n", int'(sys_rst_n), 0);
      check("reset_ready", int'(ready), 0);
      check("reset_relock", int'(relock_cnt), 0);
      check("reset_heartbeat", int'(heartbeat), 0);

      // Scenario 1: steady lock
      pll_locked = 1'b1;
      wait_rst(1'b1, n);
      check("s1_rise_edges", n, 15);
      check("s1_ready", int'(ready), 1);
      check("s1_relock", int'(relock_cnt), 0);

      // Heartbeat period in RUN
      align();
      first_t = -1; last_t = -1; prev_hb = int'(heartbeat);
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (int'(heartbeat) != prev_hb) begin
            if (last_t < 0) first_t = i;
            else check("hb_period", i - last_t, 4);
            last_t  = i;
            prev_hb = int'(heartbeat);
         end
      end
      check("hb_first_toggle", first_t, 4);

      // Scenario 4: soft reset pulse
      align();
      soft_rst_req = 1'b1;
      lows = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (i == 1) soft_rst_req = 1'b0;
         if (!sys_rst_n) lows++;
      end
      check("s4_low_cycles", lows, 4);
      check("s4_back_high", int'(sys_rst_n), 1);
      check("s4_relock", int'(relock_cnt), 0);

      // Scenario 3: lock loss in RUN
      align();
      pll_locked = 1'b0;
      wait_rst(1'b0, n);
      check("s3_fall_edges", n, 3);
      check("s3_relock", int'(relock_cnt), 1);
      align();
      pll_locked = 1'b1;
      wait_rst(1'b1, n);
      check("s3_relock_rise_edges", n, 15);

      // Scenario 5: loss and soft request land on the same FSM edge
      align();
      pll_locked = 1'b0;
      tick(2);
      soft_rst_req = 1'b1;
      tick(1);
      soft_rst_req = 1'b0;
      tick(2);
      check("s5_relock", int'(relock_cnt), 2);
      check("s5_ready", int'(ready), 0);

      // Scenario 2: short lock then re-lock
      pll_locked = 1'b1;
      tick(5);
      pll_locked = 1'b0;
      tick(6);
      check("s2_still_reset", int'(sys_rst_n), 0);
      pll_locked = 1'b1;
      wait_rst(1'b1, n);
      check("s2_rise_edges", n, 15);
      check("s2_relock", int'(relock_cnt), 2);

      // Scenario 3 continued: 300 losses in total saturate the counter
      for (int k = 3; k <= 300; k++) begin
         align();
         pll_locked = 1'b0;
         tick(4);
         pll_locked = 1'b1;
         wait_rst(1'b1, n);
      end
      check("s3_saturated", int'(relock_cnt), 255);

      // Scenario 6: board reset asserted during HOLD
      align();
      pll_locked = 1'b0;
      tick(4);
      pll_locked = 1'b1;
      tick(12);
      rst_n = 1'b0;
      #1;
      check("s6_async_sys_rst_n", int'(sys_rst_n), 0);
      check("s6_async_ready", int'(ready), 0);
      check("s6_async_relock", int'(relock_cnt), 0);
      check("s6_async_heartbeat", int'(heartbeat), 0);
      tick(2);
      rst_n = 1'b1;
      wait_rst(1'b1, n);
      check("s6_restart_rise_edges", n, 15);
      check("s6_restart_relock", int'(relock_cnt), 0);
      tick(3);

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
